// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: IFU fetch and LSU access share one slave port,
// LSU priority with IFU starvation guard, bus timeout and flush drop.
module bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        flush_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    output logic        if_err_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_sel_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic        mem_err_o,
    output logic        stallreq_if_o,
    output logic        stallreq_mem_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_sel_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

    state_t        state;
    logic [SW-1:0] streak;
    logic [7:0]    tmo_cnt;
    logic          drop;

    logic busy;
    logic if_own;
    logic mem_own;
    logic if_live;
    logic tmo;
    logic done;
    logic starved;
    logic pick_if;
    logic pick_mem;

    always_comb begin
        busy     = (state != IDLE);
        if_own   = (state == IF_BUSY);
        mem_own  = (state == MEM_BUSY);
        // a flush in the completion cycle also suppresses the IFU response
        if_live  = if_own & ~drop & ~flush_i;
        tmo      = busy & ~bus_ack_i & (tmo_cnt == 8'(TIMEOUT));
        done     = busy & (bus_ack_i | tmo);
        starved  = (streak == SW'(STARVE_LIMIT));
        pick_if  = if_req_i & ~flush_i & (~mem_req_i | starved);
        pick_mem = mem_req_i & ~pick_if;
    end

    assign if_ack_o       = if_live & done;
    assign if_err_o       = if_live & tmo;
    assign if_rdata_o     = (if_live & bus_ack_i) ? bus_rdata_i : 32'h0;
    assign mem_ack_o      = mem_own & done;
    assign mem_err_o      = mem_own & tmo;
    assign mem_rdata_o    = (mem_own & bus_ack_i) ? bus_rdata_i : 32'h0;
    assign stallreq_if_o  = if_req_i & ~if_ack_o;
    assign stallreq_mem_o = mem_req_i & ~mem_ack_o;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state       <= IDLE;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'h0;
            bus_wdata_o <= 32'h0;
            bus_sel_o   <= 4'h0;
            streak      <= '0;
            tmo_cnt     <= 8'h0;
            drop        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (pick_if) begin
                        state       <= IF_BUSY;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_addr_o  <= if_addr_i;
                        bus_wdata_o <= 32'h0;
                        bus_sel_o   <= 4'hf;
                        streak      <= '0;
                        tmo_cnt     <= 8'h0;
                    end else if (pick_mem) begin
                        state       <= MEM_BUSY;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_addr_o  <= mem_addr_i;
                        bus_wdata_o <= mem_wdata_i;
                        bus_sel_o   <= mem_sel_i;
                        tmo_cnt     <= 8'h0;
                        if (!if_req_i)
                            streak <= '0;
                        else if (!starved)
                            streak <= streak + SW'(1);
                    end
                end
                IF_BUSY, MEM_BUSY: begin
                    if (done) begin
                        state     <= IDLE;
                        bus_req_o <= 1'b0;
                        drop      <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'h1;
                        if (if_own && flush_i)
                            drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
